scratchpad_arbiter: RTL
=======================

Name: scratchpad_arbiter

Overview:
- Shares one scratchpad RAM (1 read port, 1 write port, 1-cycle registered read, active-low write strobe, no byte enables) between two requesters.
- M0 is instruction fetch (read-only). M1 is load/store (read/write with byte enables).
- Round-robin arbitration, req/gnt handshake, fixed read latency.
- Sub-word writes use a two-cycle read-modify-write. Sits between the CPU front/back end and the RAM instance.

Parameters:
BITS, 32, RAM word width; multiple of 8
ADDRESS_BITS, 10, word address width
BE_BITS, BITS/8, byte-enable width (derived, localparam)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
m0_req  in  1  fetch read request
m0_addr  in  ADDRESS_BITS  fetch word address
m0_gnt  out  1  request accepted this cycle
m0_rvalid  out  1  m0_rdata valid (one cycle after gnt)
m0_rdata  out  BITS  fetch data
m1_req  in  1  load/store request
m1_we  in  1  1=write, 0=read
m1_be  in  BE_BITS  byte enables for writes (bit i -> byte i)
m1_addr  in  ADDRESS_BITS  word address
m1_wdata  in  BITS  write data
m1_gnt  out  1  request accepted this cycle
m1_rvalid  out  1  m1_rdata valid (reads only)
m1_rdata  out  BITS  load data
ram_rd_addr  out  ADDRESS_BITS  to RAM rd_addr
ram_wr_addr  out  ADDRESS_BITS  to RAM wr_addr
ram_wr_data  out  BITS  to RAM data_in
ram_WRb  out  1  to RAM WRb, active low
ram_rd_data  in  BITS  from RAM data_out

Behaviour:
- State machine: IDLE, MERGE. Registers: state, last_gnt (0/1), rvalid flags, merge address / data / be.
- Reset (RST=1 at posedge): state=IDLE, last_gnt=1 (M0 wins first contention), m0_rvalid=m1_rvalid=0. While RST=1: gnt outputs 0, ram_WRb=1. RST mid-MERGE abandons the merge; no RAM write occurs.
- Grants:
  - Combinational, only in IDLE with RST=0. At most one gnt per cycle.
  - Single requester: granted.
  - Both requesting: grant the one != last_gnt.
  - last_gnt <= granted id on every grant.
  - A requester holds req/addr/data until it sees gnt.
- Read grant (M0, or M1 with we=0): ram_rd_addr=addr in the grant cycle. rvalid for that master is 1 the next cycle, with rdata=ram_rd_data. Throughput 1 read per cycle.
- Full write (m1_we=1, be all ones): ram_wr_addr=addr, ram_wr_data=wdata, ram_WRb=0 in the grant cycle. Completes in 1 cycle, no rvalid.
- Zero-byte write (be=0): granted, no RAM write, 1 cycle.
- Partial write (be neither 0 nor all ones):
  - Grant cycle: ram_rd_addr=addr; latch addr/wdata/be; state->MERGE.
  - MERGE cycle: ram_wr_data = byte-wise merge (be[i] ? wdata byte i : ram_rd_data byte i), ram_wr_addr=latched addr, ram_WRb=0. No grants issued. state->IDLE.
- Ordering: a read granted the cycle after a write completes returns the new data. The RAM's same-edge read-before-write never arises, because no read is granted in MERGE.
- ram_WRb=1 in every cycle not listed above. ram_rd_addr is don't-care when no read is issued and holds last value. rdata is don't-care while rvalid=0.
- Address wrap: none. Addresses pass through unmodified.

Decomposition:
- Package scratchpad_arb_pkg holds:
  - state encodings (ST_IDLE, ST_MERGE)
  - master ids (M_FETCH=0, M_LSU=1)
  - function byte_merge(old, new, be), parameterised via BITS
- No sub-module. The RAM is instantiated by the parent, alongside this block.

Test Plan:
- Reset then m0_req addr 0x005 (RAM[5]=0xDEADBEEF) -> m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1_rvalid=0.
- Both req every cycle, m0 reads 0x001, m1 reads 0x002 -> gnt order M0,M1,M0,M1; each rvalid exactly 1 cycle after its gnt.
- m1 write 0x010, be=4'b1111, wdata 0x12345678 -> ram_WRb=0 for 1 cycle; following m0 read of 0x010 returns 0x12345678.
- RAM[0x020]=0xAABBCCDD; m1 write be=4'b0101, wdata 0x11223344 -> gnt then 1 MERGE cycle with m0_req high but m0_gnt=0; RAM[0x020]=0xAA22CC44; m0 granted the cycle after.
- m1 write be=0 to 0x030 holding 0x55 -> granted, ram_WRb never 0, RAM[0x030]=0x55.
- Partial write granted, RST=1 in MERGE cycle -> ram_WRb stays 1, RAM unchanged, all gnt/rvalid=0; after RST, contention grants M0 first.

Source files
------------

// File: rtl/scratchpad_arbiter_pkg.sv
// Shared types and helpers for the two-master scratchpad arbiter.
// Holds the FSM state encoding, the master ids and the byte merge used by read-modify-write.
package scratchpad_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } arb_state_t;

    localparam logic M_FETCH = 1'b0;
    localparam logic M_LSU   = 1'b1;

    // One byte lane of a sub-word write; callers loop over BITS/8 lanes.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        byte_merge = be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/scratchpad_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the scratchpad arbiter.
// master = CPU requesters, slave = arbiter, ram = the scratchpad RAM instance.
interface scratchpad_arbiter_if #(
    parameter int BITS         = 32,
    parameter int ADDRESS_BITS = 10
);
    localparam int BE_BITS = BITS / 8;

    logic                    m0_req;
    logic [ADDRESS_BITS-1:0] m0_addr;
    logic                    m0_gnt;
    logic                    m0_rvalid;
    logic [BITS-1:0]         m0_rdata;

    logic                    m1_req;
    logic                    m1_we;
    logic [BE_BITS-1:0]      m1_be;
    logic [ADDRESS_BITS-1:0] m1_addr;
    logic [BITS-1:0]         m1_wdata;
    logic                    m1_gnt;
    logic                    m1_rvalid;
    logic [BITS-1:0]         m1_rdata;

    logic [ADDRESS_BITS-1:0] ram_rd_addr;
    logic [ADDRESS_BITS-1:0] ram_wr_addr;
    logic [BITS-1:0]         ram_wr_data;
    logic                    ram_WRb;
    logic [BITS-1:0]         ram_rd_data;

    modport master (
        output m0_req, m0_addr,
        output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata
    );

    modport slave (
        input  m0_req, m0_addr,
        input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_rd_addr, ram_wr_addr, ram_wr_data, ram_WRb,
        input  ram_rd_data
    );

    modport ram (
        input  ram_rd_addr, ram_wr_addr, ram_wr_data, ram_WRb,
        output ram_rd_data
    );

endinterface

// File: rtl/scratchpad_arbiter.sv
// Round-robin arbiter sharing one 1R1W scratchpad RAM between instruction fetch (M0)
// and load/store (M1); sub-word stores become a two-cycle read-modify-write.
module scratchpad_arbiter
    import scratchpad_arb_pkg::*;
#(
    parameter int BITS         = 32,
    parameter int ADDRESS_BITS = 10
) (
    input  logic              CLK,
    input  logic              RST,
    scratchpad_arbiter_if.slave bus
);
    localparam int BE_BITS = BITS / 8;

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic                    r_last_gnt;
    logic                    r_m0_rvalid;
    logic                    r_m1_rvalid;
    logic [ADDRESS_BITS-1:0] r_rd_addr;
    logic [ADDRESS_BITS-1:0] r_mrg_addr;
    logic [BITS-1:0]         r_mrg_wdata;
    logic [BE_BITS-1:0]      r_mrg_be;

    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_m1_full;
    logic                    w_m1_part;
    logic                    w_latch_merge;
    logic [ADDRESS_BITS-1:0] w_rd_addr;
    logic [ADDRESS_BITS-1:0] w_wr_addr;
    logic [BITS-1:0]         w_wr_data;
    logic [BITS-1:0]         w_merged;
    logic                    w_WRb;

    assign w_m1_full     = &bus.m1_be;
    assign w_m1_part     = !w_m1_full && (|bus.m1_be);
    assign w_latch_merge = w_gnt1 && bus.m1_we && w_m1_part;

    // Grants only exist in IDLE; on contention the master not served last wins.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == ST_IDLE && !RST) begin
            if (bus.m0_req && (!bus.m1_req || r_last_gnt == M_LSU)) begin
                w_gnt0 = 1'b1;
            end else if (bus.m1_req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        w_merged = '0;
        for (int i = 0; i < BE_BITS; i++) begin
            w_merged[i*8 +: 8] = byte_merge(bus.ram_rd_data[i*8 +: 8],
                                            r_mrg_wdata[i*8 +: 8], r_mrg_be[i]);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_addr    = r_rd_addr;
        w_wr_addr    = r_mrg_addr;
        w_wr_data    = w_merged;
        w_WRb        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt0) begin
                    w_rd_addr = bus.m0_addr;
                end else if (w_gnt1) begin
                    if (!bus.m1_we) begin
                        w_rd_addr = bus.m1_addr;
                    end else if (w_m1_full) begin
                        w_wr_addr = bus.m1_addr;
                        w_wr_data = bus.m1_wdata;
                        w_WRb     = 1'b0;
                    end else if (w_m1_part) begin
                        w_rd_addr    = bus.m1_addr;
                        w_next_state = ST_MERGE;
                    end
                end
            end
            ST_MERGE: begin
                // Reset here abandons the merge without touching the RAM.
                if (!RST) begin
                    w_WRb = 1'b0;
                end
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= M_LSU;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_m0_rvalid <= w_gnt0;
            r_m1_rvalid <= w_gnt1 && !bus.m1_we;
            if (w_gnt0) begin
                r_last_gnt <= M_FETCH;
            end else if (w_gnt1) begin
                r_last_gnt <= M_LSU;
            end
        end
    end

    always_ff @(posedge CLK) begin
        r_rd_addr <= w_rd_addr;
        if (w_latch_merge) begin
            r_mrg_addr  <= bus.m1_addr;
            r_mrg_wdata <= bus.m1_wdata;
            r_mrg_be    <= bus.m1_be;
        end
    end

    assign bus.m0_gnt      = w_gnt0;
    assign bus.m1_gnt      = w_gnt1;
    assign bus.m0_rvalid   = r_m0_rvalid;
    assign bus.m1_rvalid   = r_m1_rvalid;
    assign bus.m0_rdata    = bus.ram_rd_data;
    assign bus.m1_rdata    = bus.ram_rd_data;
    assign bus.ram_rd_addr = w_rd_addr;
    assign bus.ram_wr_addr = w_wr_addr;
    assign bus.ram_wr_data = w_wr_data;
    assign bus.ram_WRb     = w_WRb;

endmodule
